// File: rtl/au_issuer.sv
// au_issuer: initiator side of the arithmetic unit ACT/DATA_VALID handshake.
// Optional statistics counters are enabled with `define AU_ISSUER_STATS_EN.
module au_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [1:0]  REQ_MOVI,
    input  logic [31:0] REQ_A,
    input  logic [31:0] REQ_B,
    input  logic [31:0] REQ_MEM,
    input  logic [31:0] REQ_IMM,
    output logic        ACT,
    output logic [1:0]  OP_CODE,
    output logic [1:0]  MOVI,
    output logic [31:0] REG_A,
    output logic [31:0] REG_B,
    output logic [31:0] MEM,
    output logic [31:0] IMM,
    input  logic [31:0] DATA,
    input  logic        DATA_VALID,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [31:0] RES_DATA,
    output logic [1:0]  RES_OP,
    output logic        RES_ERR
`ifdef AU_ISSUER_STATS_EN
    ,
    output logic [15:0] OPS_COUNT,
    output logic [7:0]  TIMEOUT_COUNT
`endif
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_timer;
    logic        r_act;
    logic [1:0]  r_op;
    logic [1:0]  r_movi;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_mem;
    logic [31:0] r_imm;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic [1:0]  r_res_op;
    logic        r_res_err;

    logic        w_capture;
    logic        w_done_ok;
    logic        w_done_tmo;
    logic        w_wait_tick;
    logic        w_release;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (REQ_VALID) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (DATA_VALID || r_timer == TMO_LAST) w_next = S_RESP;
            S_RESP:  if (RES_READY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // DATA_VALID on the last timeout cycle takes priority over the timeout.
    always_comb begin
        REQ_READY   = (r_state == S_IDLE);
        w_capture   = (r_state == S_IDLE) && REQ_VALID;
        w_done_ok   = (r_state == S_WAIT) && DATA_VALID;
        w_done_tmo  = (r_state == S_WAIT) && !DATA_VALID && (r_timer == TMO_LAST);
        w_wait_tick = (r_state == S_WAIT) && !DATA_VALID && (r_timer != TMO_LAST);
        w_release   = (r_state == S_RESP) && RES_READY;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_act       <= 1'b0;
            r_op        <= '0;
            r_movi      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_mem       <= '0;
            r_imm       <= '0;
            r_timer     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_act <= w_capture;
            // AU-side lines are only ever loaded here, so they stay put until the next op.
            if (w_capture) begin
                r_op   <= REQ_OP;
                r_movi <= REQ_MOVI;
                r_a    <= REQ_A;
                r_b    <= REQ_B;
                r_mem  <= REQ_MEM;
                r_imm  <= REQ_IMM;
            end

            if (r_state == S_ISSUE) r_timer <= '0;
            else if (w_wait_tick)   r_timer <= r_timer + 8'd1;

            if (w_done_ok) begin
                r_res_valid <= 1'b1;
                r_res_data  <= DATA;
                r_res_op    <= r_op;
                r_res_err   <= 1'b0;
            end else if (w_done_tmo) begin
                r_res_valid <= 1'b1;
                r_res_data  <= '0;
                r_res_op    <= r_op;
                r_res_err   <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef AU_ISSUER_STATS_EN
    logic [15:0] r_ops_count;
    logic [7:0]  r_tmo_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ops_count <= '0;
            r_tmo_count <= '0;
        end else begin
            if (w_capture)                        r_ops_count <= r_ops_count + 16'd1;
            if (w_done_tmo && r_tmo_count != 8'hFF) r_tmo_count <= r_tmo_count + 8'd1;
        end
    end

    assign OPS_COUNT     = r_ops_count;
    assign TIMEOUT_COUNT = r_tmo_count;
`endif

    assign ACT       = r_act;
    assign OP_CODE   = r_op;
    assign MOVI      = r_movi;
    assign REG_A     = r_a;
    assign REG_B     = r_b;
    assign MEM       = r_mem;
    assign IMM       = r_imm;
    assign RES_VALID = r_res_valid;
    assign RES_DATA  = r_res_data;
    assign RES_OP    = r_res_op;
    assign RES_ERR   = r_res_err;

endmodule

// File: tb/tb_au_issuer.sv
// Directed testbench for au_issuer with a behavioural arithmetic unit model.
module tb_au_issuer;

    logic        CLK;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_OP;
    logic [1:0]  REQ_MOVI;
    logic [31:0] REQ_A, REQ_B, REQ_MEM, REQ_IMM;
    logic        ACT;
    logic [1:0]  OP_CODE, MOVI;
    logic [31:0] REG_A, REG_B, MEM, IMM;
    logic [31:0] DATA;
    logic        DATA_VALID;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_OP;
    logic        RES_ERR;
`ifdef AU_ISSUER_STATS_EN
    logic [15:0] ops_count;
    logic [7:0]  tmo_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    au_issuer #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_MEM(REQ_MEM), .REQ_IMM(REQ_IMM),
        .ACT(ACT), .OP_CODE(OP_CODE), .MOVI(MOVI),
        .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
        .DATA(DATA), .DATA_VALID(DATA_VALID),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_OP(RES_OP), .RES_ERR(RES_ERR)
`ifdef AU_ISSUER_STATS_EN
        , .OPS_COUNT(ops_count), .TIMEOUT_COUNT(tmo_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Arithmetic unit model: mode 0 real (1-cycle ops, MUL 4 cycles), 1 never answers,
    // 2 answers 0xDEADBEEF after au_delay+1 cycles.
    int          au_mode  = 0;
    int          au_delay = 0;
    int          au_cnt;
    logic        au_dv;
    logic [31:0] au_data;

    function automatic logic [31:0] au_opb(input logic [1:0] sel, input logic [31:0] b, m, i);
        case (sel)
            2'd0:    return b;
            2'd1:    return m;
            2'd2:    return i;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] au_alu(input logic [1:0] op, input logic [31:0] a, b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 0) ? 32'd0 : a / b;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            au_dv   <= 1'b0;
            au_cnt  <= 0;
            au_data <= '0;
        end else begin
            au_dv <= 1'b0;
            if (ACT) begin
                if (au_mode == 2)          au_cnt <= au_delay;
                else if (au_mode == 1)     au_cnt <= 0;
                else if (OP_CODE == 2'd2)  au_cnt <= 3;
                else begin
                    au_dv   <= 1'b1;
                    au_data <= au_alu(OP_CODE, REG_A, au_opb(MOVI, REG_B, MEM, IMM));
                end
            end else if (au_cnt > 0) begin
                au_cnt <= au_cnt - 1;
                if (au_cnt == 1) begin
                    au_dv   <= 1'b1;
                    au_data <= (au_mode == 2) ? 32'hDEADBEEF
                                              : au_alu(OP_CODE, REG_A, au_opb(MOVI, REG_B, MEM, IMM));
                end
            end
        end
    end

    assign DATA_VALID = au_dv;
    assign DATA       = au_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, movi, input logic [31:0] a, b, m, i);
        REQ_OP = op; REQ_MOVI = movi;
        REQ_A = a; REQ_B = b; REQ_MEM = m; REQ_IMM = i;
        REQ_VALID = 1'b1;
        check("req_ready_idle", REQ_READY, 1);
        tick();
        REQ_VALID = 1'b0;
        check("act_after_accept", ACT, 1);
        check("reg_a_captured", REG_A, a);
    endtask

    task automatic wait_res(output int lat, output int act_n, output bit stable);
        logic [133:0] snap;
        snap   = {OP_CODE, MOVI, REG_A, REG_B, MEM, IMM};
        lat    = 0;
        act_n  = 0;
        stable = 1'b1;
        while (RES_VALID !== 1'b1 && lat < 40) begin
            if (ACT) act_n++;
            if ({OP_CODE, MOVI, REG_A, REG_B, MEM, IMM} !== snap) stable = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, movi,
                          input logic [31:0] a, b, m, i,
                          input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        int lat, act_n;
        bit stable;
        issue(op, movi, a, b, m, i);
        wait_res(lat, act_n, stable);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_act_cycles"}, act_n, 1);
        check({tag, "_au_stable"}, stable, 1);
        check({tag, "_data"}, RES_DATA, exp_data);
        check({tag, "_op"}, RES_OP, op);
        check({tag, "_err"}, RES_ERR, exp_err);
        tick();
        check({tag, "_released"}, RES_VALID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, act_n;
        bit  stable;
        bit  held_ok;

        RST_N = 1'b0; REQ_VALID = 1'b0; RES_READY = 1'b1;
        REQ_OP = '0; REQ_MOVI = '0; REQ_A = '0; REQ_B = '0; REQ_MEM = '0; REQ_IMM = '0;
        tick(); tick();
        check("rst_act", ACT, 0);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_res_err", RES_ERR, 0);
        check("rst_res_data", RES_DATA, 0);
        check("rst_reg_a", REG_A, 0);
        check("rst_req_ready", REQ_READY, 1);
        RST_N = 1'b1;
        tick();

        run_op("add", 2'd0, 2'd0, 32'd5, 32'd3, 32'd0, 32'd0, 2, 32'd8, 1'b0);
        run_op("mul", 2'd2, 2'd2, 32'd7, 32'd0, 32'd0, 32'd6, 5, 32'd42, 1'b0);
        run_op("add_mem", 2'd0, 2'd1, 32'd100, 32'd0, 32'd23, 32'd0, 2, 32'd123, 1'b0);
        run_op("div_zero", 2'd3, 2'd3, 32'd10, 32'd0, 32'd0, 32'd0, 2, 32'd0, 1'b0);
        run_op("sub", 2'd1, 2'd0, 32'd10, 32'd4, 32'd0, 32'd0, 2, 32'd6, 1'b0);

        au_mode = 1;
        run_op("timeout", 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 9, 32'd0, 1'b1);
        au_mode = 2; au_delay = 7;
        run_op("dv_last", 2'd1, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 9, 32'hDEADBEEF, 1'b0);
        au_mode = 0;
`ifdef AU_ISSUER_STATS_EN
        check("stats_ops_7", ops_count, 7);
        check("stats_tmo_1", tmo_count, 1);
`endif

        // Response back-pressure with a new request pending.
        RES_READY = 1'b0;
        issue(2'd0, 2'd0, 32'd2, 32'd3, 32'd0, 32'd0);
        wait_res(lat, act_n, stable);
        check("bp_latency", lat, 2);
        REQ_OP = 2'd1; REQ_MOVI = 2'd0; REQ_A = 32'd9; REQ_B = 32'd2;
        REQ_VALID = 1'b1;
        held_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (RES_VALID !== 1'b1 || RES_DATA !== 32'd5 || REQ_READY !== 1'b0 || ACT !== 1'b0)
                held_ok = 1'b0;
        end
        check("bp_held", held_ok, 1);
        RES_READY = 1'b1;
        tick();
        check("bp_release_ready", REQ_READY, 1);
        check("bp_release_no_act", ACT, 0);
        check("bp_release_valid", RES_VALID, 0);
        tick();
        REQ_VALID = 1'b0;
        check("bp_next_act", ACT, 1);
        wait_res(lat, act_n, stable);
        check("bp_next_data", RES_DATA, 7);
        check("bp_next_op", RES_OP, 1);
        tick();

        // Asynchronous reset during the WAIT of a multiply.
        issue(2'd2, 2'd0, 32'd3, 32'd4, 32'd0, 32'd0);
        tick(); tick();
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_act", ACT, 0);
        check("mid_rst_res_valid", RES_VALID, 0);
        check("mid_rst_reg_a", REG_A, 0);
        check("mid_rst_op_code", OP_CODE, 0);
        check("mid_rst_req_ready", REQ_READY, 1);
        tick();
        RST_N = 1'b1;
        held_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (RES_VALID !== 1'b0 || ACT !== 1'b0) held_ok = 1'b0;
        end
        check("mid_rst_no_response", held_ok, 1);
        run_op("add_after_rst", 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 32'd0, 2, 32'd2, 1'b0);
`ifdef AU_ISSUER_STATS_EN
        check("stats_ops_after_rst", ops_count, 1);
        check("stats_tmo_after_rst", tmo_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
